// File: rtl/mealy_seq_tx.sv
// Parallel-in, serial-out word transmitter, MSB first, with valid/ready input.
// Define SEQ_TX_PARITY_EN to append one even-parity bit after each word.
module mealy_seq_tx #(
    parameter int   WIDTH      = 8,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             x_out,
    output logic             x_valid,
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

`ifdef SEQ_TX_PARITY_EN
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_PAR   = 2'd2,
        S_DONE  = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd3
    } state_t;
`endif

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    cnt_q, cnt_d;

`ifdef SEQ_TX_PARITY_EN
    logic par_q, par_d;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
`ifdef SEQ_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
`ifdef SEQ_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
`ifdef SEQ_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (din_valid) begin
                    state_d = S_SHIFT;
                    shift_d = din;
                    cnt_d   = CNT_MAX;
`ifdef SEQ_TX_PARITY_EN
                    par_d   = ^din;
`endif
                end
            end
            S_SHIFT: begin
                shift_d = {shift_q[WIDTH-2:0], 1'b0};
                cnt_d   = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    cnt_d = '0;
`ifdef SEQ_TX_PARITY_EN
                    state_d = S_PAR;
`else
                    state_d = S_DONE;
`endif
                end
            end
`ifdef SEQ_TX_PARITY_EN
            S_PAR:  state_d = S_DONE;
`endif
            S_DONE: state_d = S_IDLE;
            default: begin
                // Stray encodings fall back to a clean idle
                state_d = S_IDLE;
                shift_d = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        din_ready = 1'b1;
        x_valid   = 1'b0;
        x_out     = IDLE_LEVEL;
        busy      = 1'b0;
        done      = 1'b0;
        case (state_q)
            S_IDLE: ;
            S_SHIFT: begin
                din_ready = 1'b0;
                x_valid   = 1'b1;
                x_out     = shift_q[WIDTH-1];
                busy      = 1'b1;
            end
`ifdef SEQ_TX_PARITY_EN
            S_PAR: begin
                din_ready = 1'b0;
                x_valid   = 1'b1;
                x_out     = par_q;
                busy      = 1'b1;
            end
`endif
            S_DONE: begin
                din_ready = 1'b0;
                busy      = 1'b1;
                done      = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/mealy_seq_tx.md
MEALY_SEQ_TX -- requirements
Module: mealy_seq_tx

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the number of data bits per word; legal range 2..32.
REQ-002 The block SHALL have parameter IDLE_LEVEL, default 1'b0, giving the value driven on x_out whenever x_valid is 0.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all logic samples on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port din, input, WIDTH bits: parallel word to serialize.
REQ-006 The block SHALL have port din_valid, input, 1 bit: din holds a word offered for transmission.
REQ-007 The block SHALL have port din_ready, output, 1 bit: the block can accept a word this cycle.
REQ-008 The block SHALL have port x_out, output, 1 bit: serial bit stream, MSB first.
REQ-009 The block SHALL have port x_valid, output, 1 bit: x_out carries a data or parity bit this cycle.
REQ-010 The block SHALL have port busy, output, 1 bit: a word is in flight.
REQ-011 The block SHALL have port done, output, 1 bit: one-cycle pulse after the last bit of a word.

Function
REQ-012 The FSM SHALL have states IDLE, SHIFT, PAR and DONE; PAR exists only when SEQ_TX_PARITY_EN is defined.
REQ-013 In IDLE: din_ready=1, x_valid=0, busy=0, done=0, x_out=IDLE_LEVEL.
REQ-014 A handshake SHALL occur on the rising edge where din_valid=1 and din_ready=1; that edge loads din into the shift register, sets the bit counter to WIDTH-1, and moves the FSM to SHIFT.
REQ-015 In SHIFT: x_valid=1, busy=1, din_ready=0, and x_out=shift register MSB, registered with no combinational path from din.
REQ-016 In SHIFT, each edge SHALL shift the register left by one and decrement the counter; on the edge where the counter equals 0, the FSM moves to PAR (parity enabled) or DONE.
REQ-017 Latency: data bit WIDTH-1-k SHALL appear on x_out in cycle k+1 after the handshake edge, for k=0..WIDTH-1.
REQ-018 In DONE: done=1, busy=1, x_valid=0, din_ready=0, x_out=IDLE_LEVEL; the next edge unconditionally moves the FSM to IDLE.
REQ-019 din and din_valid SHALL be ignored whenever din_ready=0, and a word offered then SHALL NOT be captured later unless re-presented in IDLE.
REQ-020 With din_valid held high, the word period SHALL be WIDTH+2 cycles, or WIDTH+3 with parity.
REQ-021 Unreachable state encodings SHALL recover to IDLE on the next edge with IDLE output values.

Reset
REQ-022 When reset=1 at a rising edge, the FSM SHALL go to IDLE, clear the shift register and counter, and discard any in-flight word regardless of state.
REQ-023 In the cycle after a reset edge, outputs SHALL be din_ready=1, x_valid=0, busy=0, done=0, x_out=IDLE_LEVEL.
REQ-024 Reset SHALL take priority over a simultaneous handshake, and no done pulse SHALL be emitted for an aborted word.

Configuration
REQ-025 When macro SEQ_TX_PARITY_EN is defined, the block SHALL register the even parity of din (XOR of all WIDTH bits) at the handshake edge and drive it for one PAR cycle after the last data bit, with x_valid=1, busy=1, din_ready=0.
REQ-026 When SEQ_TX_PARITY_EN is undefined, the block SHALL contain no parity register and no PAR state, and SHIFT SHALL go directly to DONE.

Verification
REQ-027 WIDTH=8, no parity, din=8'hA5 pulsed with din_valid: x_out SHALL be 1,0,1,0,0,1,0,1 with x_valid=1 in cycles 1-8, done=1 in cycle 9, and din_ready=1 in cycle 10.
REQ-028 Parity enabled, din=8'hA5 SHALL give parity bit 0 in cycle 9 and done in cycle 10; din=8'h07 SHALL give parity bit 1.
REQ-029 Reset asserted during the 4th data bit of 8'hFF SHALL give, in the next cycle, x_valid=0, x_out=IDLE_LEVEL and din_ready=1, with no done pulse.
REQ-030 din_valid held high with 8'h81 then 8'h3C SHALL give handshakes exactly 10 cycles apart (11 with parity), with both words serialized intact.
REQ-031 din changed to 8'h00 with din_valid=1 during SHIFT of 8'hC3 SHALL leave x_out following 8'hC3 bits, and 8'h00 SHALL be accepted only at the next IDLE.
REQ-032 IDLE_LEVEL=1 with no traffic SHALL hold x_out=1 and x_valid=0 indefinitely.
